sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of client channels (1..8).
REQ-002 SHALL have parameter REF_CYCLES, default 750, meaning clk cycles between auto-refresh requests (15 us at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning engine watchdog limit in cycles (used only under REQ-030).
REQ-004 Ports: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 init_done  input  1  level; SDRAM init sequence complete.
REQ-008 ch_req  input  NUM_CH  per-channel level request, held until granted.
REQ-009 ch_we  input  NUM_CH  per-channel direction: 1 = write burst, 0 = read burst.
REQ-010 ch_gnt  output  NUM_CH  one-hot grant, held for the whole burst.
REQ-011 wr_en / rd_en / aref_en  output  1 each  engine start levels, mutually exclusive.
REQ-012 eng_done / aref_done  input  1 each  single-cycle completion pulses from burst and refresh engines.
REQ-013 ref_pend  output  1  refresh pending; burst engine ends at next burst boundary.
REQ-014 ref_miss  output  1  sticky: refresh interval elapsed while ref_pend already set.
REQ-015 busy  output  1  high in any state except ARBIT.

Function
REQ-016 States: WAIT_INIT, ARBIT, AREF, WRITE, READ; registered, one-hot or binary encoding.
REQ-017 WAIT_INIT -> ARBIT on first cycle init_done = 1; refresh counter held at 0 until then.
REQ-018 Refresh counter counts 0..REF_CYCLES-1, wraps, sets ref_pend on wrap; ref_pend cleared on aref_done.
REQ-019 Wrap while ref_pend = 1: ref_pend stays 1, ref_miss set; no double refresh queued.
REQ-020 ARBIT priority: ref_pend beats any ch_req; simultaneous ref_pend and ch_req -> AREF.
REQ-021 Channel choice round-robin: first requesting index after last granted index, wrapping NUM_CH-1 -> 0; after reset last granted = NUM_CH-1, so channel 0 wins first.
REQ-022 ARBIT -> WRITE/READ per ch_we of winner; ch_gnt and wr_en/rd_en asserted the cycle after the decision (1-cycle latency) and held until eng_done.
REQ-023 WRITE/READ -> ARBIT on eng_done; ch_gnt, wr_en, rd_en deasserted in the same transition; pointer updated to winner.
REQ-024 AREF: aref_en high until aref_done, then -> ARBIT.
REQ-025 eng_done coincident with counter wrap: state -> ARBIT, ref_pend = 1, next decision AREF.
REQ-026 ch_req deasserted mid-burst is ignored; burst completes.
REQ-027 eng_done or aref_done outside the matching state SHALL be ignored.
REQ-028 init_done falling in any state -> WAIT_INIT next cycle, all outputs to reset values, ref_miss kept.

Reset
REQ-029 rst_n low: state WAIT_INIT, counter 0, ch_gnt 0, wr_en/rd_en/aref_en 0, ref_pend 0, ref_miss 0, busy 1, pointer NUM_CH-1; effective immediately and asynchronously, including mid-burst.

Configuration
REQ-030 Macro SDRAM_ARB_TIMEOUT_EN defined: watchdog counts cycles in WRITE/READ/AREF; at TIMEOUT without done pulse -> ARBIT, sticky output eng_timeout set; undefined: no watchdog, eng_timeout port absent, states wait indefinitely.

Structure
REQ-031 Shared package sdram_pkg SHALL hold the state enumeration and default REF_CYCLES/TIMEOUT constants.
REQ-032 Round-robin selector SHALL be one sub-module rr_pick (request vector + pointer in, one-hot winner out, combinational).

Verification
REQ-033 init_done=1, ch_req=2'b01, ch_we=2'b01 -> ch_gnt=01, wr_en=1 two cycles later; eng_done -> both 0 next cycle.
REQ-034 ch_req=2'b11 held, four eng_done pulses -> grant order ch0, ch1, ch0, ch1.
REQ-035 REF_CYCLES=16, no requests -> ref_pend at cycle 16 after init_done, aref_en next cycle, cleared on aref_done.
REQ-036 ref_pend and ch_req=01 same cycle in ARBIT -> AREF first, then WRITE/READ for ch0.
REQ-037 Hold aref_done low across two refresh intervals -> ref_miss=1, stays 1 after aref_done.
REQ-038 rst_n low mid-WRITE -> ch_gnt=0, wr_en=0 without clock edge; with SDRAM_ARB_TIMEOUT_EN, TIMEOUT=32, no eng_done -> eng_timeout=1 at cycle 32, state ARBIT.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared state enumeration, default timing constants and width helper for the SDRAM arbiter
package sdram_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_INIT,
      ST_ARBIT,
      ST_AREF,
      ST_WRITE,
      ST_READ
   } arb_state_t;

   localparam int REF_CYCLES_DEF = 750;
   localparam int TIMEOUT_DEF    = 1024;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - client request/grant and engine start/done bundle for the SDRAM arbiter
interface sdram_arbiter_if #(
   parameter int NUM_CH = 2
) ();

   logic [NUM_CH-1:0] ch_req;
   logic [NUM_CH-1:0] ch_we;
   logic [NUM_CH-1:0] ch_gnt;
   logic              wr_en;
   logic              rd_en;
   logic              aref_en;
   logic              eng_done;
   logic              aref_done;

   modport master (
      output ch_req, ch_we, eng_done, aref_done,
      input  ch_gnt, wr_en, rd_en, aref_en
   );

   modport slave (
      input  ch_req, ch_we, eng_done, aref_done,
      output ch_gnt, wr_en, rd_en, aref_en
   );

endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// rtl/sdram_arbiter_rr_pick.sv - combinational round-robin picker: first request after the pointer, wrapping
module rr_pick #(
   parameter int NUM_CH = 2,
   parameter int IW     = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IW-1:0]     ptr,
   output logic [NUM_CH-1:0] gnt
);

   logic [NUM_CH-1:0] hi;
   logic [NUM_CH-1:0] lo;
   logic              hi_hit;
   logic              lo_hit;

   // Lowest requester above the pointer wins; otherwise lowest at or below it (the wrap).
   always_comb begin
      hi     = '0;
      lo     = '0;
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req[i]) begin
            if (i > int'(ptr)) begin
               if (!hi_hit) begin
                  hi[i]  = 1'b1;
                  hi_hit = 1'b1;
               end
            end else if (!lo_hit) begin
               lo[i]  = 1'b1;
               lo_hit = 1'b1;
            end
         end
      end
      gnt = hi_hit ? hi : lo;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM arbiter top: refresh scheduling plus round-robin bursts; SDRAM_ARB_TIMEOUT_EN adds an engine watchdog
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int REF_CYCLES = REF_CYCLES_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           init_done,
   sdram_arbiter_if.slave bus,
   output logic           ref_pend,
   output logic           ref_miss,
   output logic           busy
`ifdef SDRAM_ARB_TIMEOUT_EN
   ,
   output logic           eng_timeout
`endif
);

   localparam int IW = cnt_width(NUM_CH);
   localparam int CW = cnt_width(REF_CYCLES);

   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("sdram_arbiter: NUM_CH must be 1..8");
   end
   if (REF_CYCLES < 2) begin : g_bad_ref_cycles
      $error("sdram_arbiter: REF_CYCLES must be at least 2");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("sdram_arbiter: TIMEOUT must be at least 2");
   end

   arb_state_t        state, state_nxt;
   logic [NUM_CH-1:0] gnt, gnt_nxt, pick;
   logic [IW-1:0]     last, last_nxt, gnt_idx;
   logic [CW-1:0]     ref_cnt;
   logic              wrap;
   logic              tmo;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .IW     (IW)
   ) u_pick (
      .req (bus.ch_req),
      .ptr (last),
      .gnt (pick)
   );

   assign wrap = (state != ST_WAIT_INIT) && (ref_cnt == CW'(REF_CYCLES - 1));

   // Index of the channel currently holding the grant, used to advance the pointer.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) gnt_idx = IW'(i);
      end
   end

   // Next state, next grant and pointer; losing init_done overrides everything.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      if (!init_done) begin
         state_nxt = ST_WAIT_INIT;
         gnt_nxt   = '0;
         last_nxt  = IW'(NUM_CH - 1);
      end else begin
         case (state)
            ST_WAIT_INIT: state_nxt = ST_ARBIT;
            ST_ARBIT: begin
               if (ref_pend) begin
                  state_nxt = ST_AREF;
               end else if (|bus.ch_req) begin
                  gnt_nxt   = pick;
                  state_nxt = (|(pick & bus.ch_we)) ? ST_WRITE : ST_READ;
               end
            end
            ST_AREF: begin
               if (bus.aref_done || tmo) state_nxt = ST_ARBIT;
            end
            ST_WRITE, ST_READ: begin
               if (bus.eng_done || tmo) begin
                  state_nxt = ST_ARBIT;
                  gnt_nxt   = '0;
                  last_nxt  = gnt_idx;
               end
            end
            default: state_nxt = ST_WAIT_INIT;
         endcase
      end
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_WAIT_INIT;
         gnt   <= '0;
         last  <= IW'(NUM_CH - 1);
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         last  <= last_nxt;
      end
   end

   // Refresh interval counter with pending/missed flags; a wrap always wins over aref_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
         ref_miss <= 1'b0;
      end else if (!init_done) begin
         ref_cnt  <= '0;
         ref_pend <= 1'b0;
      end else if (state == ST_WAIT_INIT) begin
         ref_cnt  <= '0;
      end else begin
         ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
         if (wrap) begin
            ref_pend <= 1'b1;
            if (ref_pend) ref_miss <= 1'b1;
         end else if (state == ST_AREF && bus.aref_done) begin
            ref_pend <= 1'b0;
         end
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int WW = cnt_width(TIMEOUT);

   logic [WW-1:0] wd;
   logic          active;
   logic          done_hit;

   assign active   = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);
   assign done_hit = ((state == ST_AREF) && bus.aref_done) ||
                     (((state == ST_WRITE) || (state == ST_READ)) && bus.eng_done);
   assign tmo      = active && (wd == WW'(TIMEOUT - 1));

   // Watchdog counts cycles spent in one engine state; expiry without a done pulse is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd          <= '0;
         eng_timeout <= 1'b0;
      end else if (!init_done) begin
         wd          <= '0;
         eng_timeout <= 1'b0;
      end else begin
         wd <= (active && state_nxt == state) ? wd + 1'b1 : '0;
         if (tmo && !done_hit) eng_timeout <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   assign bus.ch_gnt  = gnt;
   assign bus.wr_en   = (state == ST_WRITE);
   assign bus.rd_en   = (state == ST_READ);
   assign bus.aref_en = (state == ST_AREF);
   assign busy        = (state != ST_ARBIT);

endmodule
